// File: rtl/aead_serial_ctrl_pkg.sv
// rtl/aead_serial_ctrl_pkg.sv - shared types and constants for the Ascon AEAD streaming front-end
package aead_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT} state_t;
  typedef enum logic [2:0] {F_KEY, F_NONCE, F_AD, F_TEXT, F_TAG} field_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  localparam int   NONCE_W  = 128;
  localparam int   TAG_W    = 128;

  function automatic int beats(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/aead_serial_ctrl_if.sv
// rtl/aead_serial_ctrl_if.sv - input/output beat streams of the AEAD front-end
interface aead_serial_ctrl_if #(parameter int W = 8);

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [W-1:0] rnd_data;

  modport master (
    output in_data, in_valid, out_ready, rnd_data,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready, rnd_data,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/aead_serial_ctrl_wshift.sv
// rtl/aead_serial_ctrl_wshift.sv - N-bit register, parallel load or W-bit MSB-first shift per beat
module aead_wshift #(
  parameter int N = 128,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         shift,
  input  logic [W-1:0] shift_in,
  output logic [N-1:0] q
);

  logic [N-1:0] shifted;

  if (N > W) begin : g_wide
    assign shifted = {q[N-W-1:0], shift_in};
  end else begin : g_narrow
    assign shifted = N'(shift_in);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/aead_serial_ctrl.sv
// rtl/aead_serial_ctrl.sv - handshaked W-bit front-end sequencing load, core start/done and result streaming
// Optional key-reuse input enabled by AEAD_KEY_REUSE_EN.
module aead_serial_ctrl
  import aead_pkg::*;
#(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
`ifdef AEAD_KEY_REUSE_EN
  input  logic                key_reuse,
`endif
  aead_serial_ctrl_if.slave   strm,
  output logic                busy,
  output logic                done,
  output logic                auth_ok,
  output logic [K-1:0]        core_key,
  output logic [NONCE_W-1:0]  core_nonce,
  output logic [L-1:0]        core_ad,
  output logic [Y-1:0]        core_text,
  output logic                core_enc_start,
  output logic                core_dec_start,
  input  logic                core_done,
  input  logic [Y-1:0]        core_text_out,
  input  logic [TAG_W-1:0]    core_tag_out
);

  if ((K % W) != 0 || (L % W) != 0 || (Y % W) != 0 || (NONCE_W % W) != 0) begin : g_bad_width
    $fatal(1, "aead_serial_ctrl: K, 128, L and Y must be multiples of W");
  end

  localparam logic [15:0] KB = 16'(beats(K, W));
  localparam logic [15:0] NB = 16'(beats(NONCE_W, W));
  localparam logic [15:0] AB = 16'(beats(L, W));
  localparam logic [15:0] TB = 16'(beats(Y, W));
  localparam logic [15:0] GB = 16'(beats(TAG_W, W));

  state_t               state;
  field_t               field;
  field_t               first_field;
  logic                 mode_q;
  logic [15:0]          cnt;
  logic [15:0]          ocnt;
  logic [15:0]          field_beats;
  logic [15:0]          out_beats;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic [W-1:0]         rnd_q;
  logic [TAG_W-1:0]     tag_q;
  logic [Y+TAG_W-1:0]   out_q;
  logic                 in_acc;
  logic                 field_end;
  logic                 last_field;
  logic                 key_shift;
  logic                 out_acc;
  logic                 capture;

  assign busy           = (state != IDLE);
  assign strm.in_ready  = in_ready_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_last  = out_last_q;
  // Failed authentication replaces every plaintext beat with the filler sampled for that beat.
  assign strm.out_data  = (mode_q == MODE_DEC && !auth_ok) ? rnd_q : out_q[Y+TAG_W-1 -: W];

  assign in_acc     = strm.in_valid && in_ready_q;
  assign field_end  = (cnt == field_beats - 16'd1);
  assign last_field = (field == F_TAG) || (field == F_TEXT && mode_q == MODE_ENC);
  assign key_shift  = in_acc && (field == F_KEY);
  assign out_acc    = out_valid_q && strm.out_ready;
  assign capture    = (state == WAIT) && core_done;
  assign out_beats  = (mode_q == MODE_DEC) ? TB : TB + GB;

  always_comb begin
    field_beats = NB;
    case (field)
      F_KEY:   field_beats = KB;
      F_NONCE: field_beats = NB;
      F_AD:    field_beats = AB;
      F_TEXT:  field_beats = TB;
      F_TAG:   field_beats = GB;
      default: field_beats = NB;
    endcase
  end

`ifdef AEAD_KEY_REUSE_EN
  // A reuse request only takes effect once a complete key has been shifted in since reset.
  logic key_loaded;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_loaded <= 1'b0;
    end else if (key_shift && field_end) begin
      key_loaded <= 1'b1;
    end
  end
  assign first_field = (key_reuse && key_loaded) ? F_NONCE : F_KEY;
`else
  assign first_field = F_KEY;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      field          <= F_KEY;
      mode_q         <= MODE_ENC;
      cnt            <= '0;
      ocnt           <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      done           <= 1'b0;
      auth_ok        <= 1'b0;
      core_enc_start <= 1'b0;
      core_dec_start <= 1'b0;
      rnd_q          <= '0;
    end else begin
      done           <= 1'b0;
      core_enc_start <= 1'b0;
      core_dec_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            auth_ok    <= 1'b0;
            cnt        <= '0;
            field      <= first_field;
            in_ready_q <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (in_acc) begin
            if (field_end) begin
              cnt <= '0;
              if (last_field) begin
                in_ready_q     <= 1'b0;
                core_enc_start <= (mode_q == MODE_ENC);
                core_dec_start <= (mode_q == MODE_DEC);
                state          <= START;
              end else begin
                field <= field_t'(field + 3'd1);
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (core_done) begin
            if (mode_q == MODE_DEC) begin
              auth_ok <= (core_tag_out == tag_q);
            end
            rnd_q       <= strm.rnd_data;
            ocnt        <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (out_beats == 16'd1);
            state       <= OUT;
          end
        end
        OUT: begin
          if (strm.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done        <= 1'b1;
              state       <= IDLE;
            end else begin
              ocnt       <= ocnt + 16'd1;
              out_last_q <= (ocnt + 16'd2 == out_beats);
              rnd_q      <= strm.rnd_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  aead_wshift #(.N(K), .W(W)) u_key (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift(key_shift), .shift_in(strm.in_data), .q(core_key)
  );

  aead_wshift #(.N(NONCE_W), .W(W)) u_nonce (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift(in_acc && field == F_NONCE), .shift_in(strm.in_data), .q(core_nonce)
  );

  aead_wshift #(.N(L), .W(W)) u_ad (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift(in_acc && field == F_AD), .shift_in(strm.in_data), .q(core_ad)
  );

  aead_wshift #(.N(Y), .W(W)) u_text (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift(in_acc && field == F_TEXT), .shift_in(strm.in_data), .q(core_text)
  );

  aead_wshift #(.N(TAG_W), .W(W)) u_tag (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift(in_acc && field == F_TAG), .shift_in(strm.in_data), .q(tag_q)
  );

  // Text sits above the tag, so decrypt simply stops after the text beats.
  aead_wshift #(.N(Y + TAG_W), .W(W)) u_out (
    .clk(clk), .rst(rst), .load(capture), .load_data({core_text_out, core_tag_out}),
    .shift(out_acc), .shift_in('0), .q(out_q)
  );

endmodule

// File: tb/tb_aead_serial_ctrl.sv
// tb/tb_aead_serial_ctrl.sv - directed self-checking bench for aead_serial_ctrl with a behavioural core
module tb_aead_serial_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
`ifdef AEAD_KEY_REUSE_EN
  logic         key_reuse;
`endif
  logic         busy, done, auth_ok;
  logic [127:0] core_key, core_nonce;
  logic [39:0]  core_ad, core_text;
  logic         core_enc_start, core_dec_start;
  logic         core_done;
  logic [39:0]  core_text_out;
  logic [127:0] core_tag_out;

  aead_serial_ctrl_if #(.W(8)) sif ();

  aead_serial_ctrl #(.K(128), .L(40), .Y(40), .W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef AEAD_KEY_REUSE_EN
    .key_reuse(key_reuse),
`endif
    .strm(sif.slave), .busy(busy), .done(done), .auth_ok(auth_ok),
    .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad), .core_text(core_text),
    .core_enc_start(core_enc_start), .core_dec_start(core_dec_start),
    .core_done(core_done), .core_text_out(core_text_out), .core_tag_out(core_tag_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] key_c, nonce_c, tag_c;
  logic [39:0]  ad_c, pt_c, ct_c;
  logic [167:0] exp_enc;
  logic         tb_key_loaded;

  int          r_n_in, r_n_out, r_n_enc, r_n_dec, r_n_last, r_last_pos;
  int          r_first_ready, r_last_in_cyc, r_pulse_cyc, r_extra, r_unstable;
  logic        r_done_seen, r_to;
  logic [7:0]  r_obuf [0:31];

  task automatic run_txn(input logic md, input logic reuse, input logic [39:0] txt,
                         input logic [127:0] tg, input logic stall, input logic noise);
    logic [7:0]  q[$];
    logic [39:0] ks, ctv;
    logic [7:0]  held;
    logic        holding, eff_reuse;
    int          idx, cyc, core_wait;
`ifdef AEAD_KEY_REUSE_EN
    eff_reuse = reuse && tb_key_loaded;
`else
    eff_reuse = 1'b0;
`endif
    q.delete();
    if (!eff_reuse) for (int i = 0; i < 16; i++) q.push_back(key_c[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) q.push_back(nonce_c[127-8*i -: 8]);
    for (int i = 0; i < 5; i++) q.push_back(ad_c[39-8*i -: 8]);
    for (int i = 0; i < 5; i++) q.push_back(txt[39-8*i -: 8]);
    if (md) for (int i = 0; i < 16; i++) q.push_back(tg[127-8*i -: 8]);
    for (int i = 0; i < 32; i++) r_obuf[i] = 8'h00;
    r_n_in = 0; r_n_out = 0; r_n_enc = 0; r_n_dec = 0; r_n_last = 0; r_last_pos = -1;
    r_first_ready = -1; r_last_in_cyc = -1; r_pulse_cyc = -1; r_extra = 0; r_unstable = 0;
    r_done_seen = 1'b0; holding = 1'b0; idx = 0; cyc = 0; core_wait = -1;
    start = 1'b1; mode = md;
`ifdef AEAD_KEY_REUSE_EN
    key_reuse = reuse;
`endif
    @(negedge clk);
    start = 1'b0;
    while (!r_done_seen && cyc < 3000) begin
      if (done) r_done_seen = 1'b1;
      if (in_ready_now() && r_first_ready < 0) r_first_ready = cyc;
      if (in_ready_now() && idx == q.size()) r_extra++;
      if (core_enc_start) r_n_enc++;
      if (core_dec_start) r_n_dec++;
      if (core_enc_start || core_dec_start) begin
        r_pulse_cyc   = cyc;
        ks            = core_key[39:0] ^ core_nonce[39:0];
        core_text_out = core_text ^ ks;
        ctv           = core_enc_start ? core_text_out : core_text;
        core_tag_out  = core_key ^ core_nonce ^ {88'h0, core_ad} ^ {88'h0, ctv};
        core_done     = 1'b0;
        core_wait     = 3;
      end else if (core_wait > 0) begin
        core_wait--;
        if (core_wait == 0) core_done = 1'b1;
      end else if (core_wait == 0 && sif.out_valid) begin
        core_done = 1'b0;
        core_wait = -1;
      end else if (core_wait < 0) begin
        core_done = noise && sif.in_ready;
        if (noise) begin core_text_out = '1; core_tag_out = '1; end
      end
      if (idx < q.size()) begin
        sif.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        sif.in_data  = q[idx];
        if (sif.in_valid && sif.in_ready) begin
          idx++;
          if (idx == q.size()) r_last_in_cyc = cyc;
        end
      end else begin
        sif.in_valid = 1'b0;
      end
      if (sif.out_valid) begin
        if (holding && sif.out_data !== held) r_unstable++;
        sif.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        sif.rnd_data  = 8'hA0 + 8'(r_n_out + 1);
        if (sif.out_ready) begin
          if (r_n_out < 32) r_obuf[r_n_out] = sif.out_data;
          if (sif.out_last) begin r_n_last++; r_last_pos = r_n_out; end
          r_n_out++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held    = sif.out_data;
        end
      end else begin
        sif.out_ready = 1'b1;
        sif.rnd_data  = 8'hA0 + 8'(r_n_out);
      end
      cyc++;
      @(negedge clk);
    end
    r_n_in = idx;
    sif.in_valid = 1'b0;
    core_done = 1'b0;
    r_to = !r_done_seen;
    if (r_done_seen && !eff_reuse) tb_key_loaded = 1'b1;
  endtask

  function automatic logic in_ready_now();
    return sif.in_ready;
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy, done, auth_ok, sif.in_ready, sif.out_valid, sif.out_last} !== 6'b0) begin
      n_errors++; $display("FAIL reset_ctrl got=%b want=000000",
                           {busy, done, auth_ok, sif.in_ready, sif.out_valid, sif.out_last});
    end
    n_checks++;
    if ({core_enc_start, core_dec_start} !== 2'b0) begin
      n_errors++; $display("FAIL reset_core_start got=%b want=00", {core_enc_start, core_dec_start});
    end
    n_checks++;
    if ({core_key, core_nonce, core_ad, core_text, sif.out_data} !== '0) begin
      n_errors++; $display("FAIL reset_buses got=%h/%h/%h/%h want=0", core_key, core_nonce, core_ad, core_text);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_encrypt();
    run_txn(1'b0, 1'b0, pt_c, 128'h0, 1'b0, 1'b0);
    n_checks++; if (r_to !== 1'b0) begin n_errors++; $display("FAIL enc_timeout got=%b want=0", r_to); end
    n_checks++; if (r_n_in !== 42) begin n_errors++; $display("FAIL enc_load_beats got=%0d want=42", r_n_in); end
    n_checks++; if (r_extra !== 0) begin n_errors++; $display("FAIL enc_extra_ready got=%0d want=0", r_extra); end
    n_checks++; if (r_first_ready !== 0) begin n_errors++; $display("FAIL enc_ready_lat got=%0d want=0", r_first_ready); end
    n_checks++; if ({r_n_enc, r_n_dec} !== {32'd1, 32'd0}) begin n_errors++; $display("FAIL enc_start_pulses got=%0d/%0d want=1/0", r_n_enc, r_n_dec); end
    n_checks++; if (r_pulse_cyc !== r_last_in_cyc + 1) begin n_errors++; $display("FAIL enc_start_lat got=%0d want=%0d", r_pulse_cyc, r_last_in_cyc + 1); end
    n_checks++; if (r_n_out !== 21) begin n_errors++; $display("FAIL enc_out_beats got=%0d want=21", r_n_out); end
    n_checks++; if ({r_n_last, r_last_pos} !== {32'd1, 32'd20}) begin n_errors++; $display("FAIL enc_out_last got=%0d@%0d want=1@20", r_n_last, r_last_pos); end
    for (int i = 0; i < 21; i++) begin
      n_checks++;
      if (r_obuf[i] !== exp_enc[167-8*i -: 8]) begin
        n_errors++; $display("FAIL enc_beat[%0d] got=%h want=%h", i, r_obuf[i], exp_enc[167-8*i -: 8]);
      end
    end
    n_checks++;
    if ({core_key, core_nonce, core_ad, core_text} !== {key_c, nonce_c, ad_c, pt_c}) begin
      n_errors++; $display("FAIL enc_core_buses got=%h %h %h %h", core_key, core_nonce, core_ad, core_text);
    end
    n_checks++; if (auth_ok !== 1'b0) begin n_errors++; $display("FAIL enc_auth_ok got=%b want=0", auth_ok); end
  endtask

  task automatic test_decrypt_ok();
    logic [39:0] exp_pt;
    exp_pt = pt_c;
    run_txn(1'b1, 1'b0, ct_c, tag_c, 1'b0, 1'b0);
    n_checks++; if (r_to !== 1'b0) begin n_errors++; $display("FAIL dec_ok_timeout got=%b want=0", r_to); end
    n_checks++; if (r_n_in !== 58) begin n_errors++; $display("FAIL dec_ok_load_beats got=%0d want=58", r_n_in); end
    n_checks++; if ({r_n_enc, r_n_dec} !== {32'd0, 32'd1}) begin n_errors++; $display("FAIL dec_ok_pulses got=%0d/%0d want=0/1", r_n_enc, r_n_dec); end
    n_checks++; if ({r_n_out, r_last_pos} !== {32'd5, 32'd4}) begin n_errors++; $display("FAIL dec_ok_out_beats got=%0d@%0d want=5@4", r_n_out, r_last_pos); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (r_obuf[i] !== exp_pt[39-8*i -: 8]) begin
        n_errors++; $display("FAIL dec_ok_beat[%0d] got=%h want=%h", i, r_obuf[i], exp_pt[39-8*i -: 8]);
      end
    end
    n_checks++; if (auth_ok !== 1'b1) begin n_errors++; $display("FAIL dec_ok_auth got=%b want=1", auth_ok); end
  endtask

  task automatic test_decrypt_fail();
    run_txn(1'b1, 1'b0, ct_c, tag_c ^ 128'h1, 1'b0, 1'b0);
    n_checks++; if (r_to !== 1'b0) begin n_errors++; $display("FAIL dec_bad_timeout got=%b want=0", r_to); end
    n_checks++; if (auth_ok !== 1'b0) begin n_errors++; $display("FAIL dec_bad_auth got=%b want=0", auth_ok); end
    n_checks++; if (r_n_out !== 5) begin n_errors++; $display("FAIL dec_bad_out_beats got=%0d want=5", r_n_out); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (r_obuf[i] !== 8'hA0 + 8'(i)) begin
        n_errors++; $display("FAIL dec_bad_beat[%0d] got=%h want=%h", i, r_obuf[i], 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_stall();
    run_txn(1'b0, 1'b0, pt_c, 128'h0, 1'b1, 1'b1);
    n_checks++; if (r_to !== 1'b0) begin n_errors++; $display("FAIL stall_timeout got=%b want=0", r_to); end
    n_checks++; if ({r_n_in, r_n_out} !== {32'd42, 32'd21}) begin n_errors++; $display("FAIL stall_counts got=%0d/%0d want=42/21", r_n_in, r_n_out); end
    n_checks++; if (r_unstable !== 0) begin n_errors++; $display("FAIL stall_hold got=%0d want=0", r_unstable); end
    n_checks++; if (r_n_last !== 1) begin n_errors++; $display("FAIL stall_last got=%0d want=1", r_n_last); end
    for (int i = 0; i < 21; i++) begin
      n_checks++;
      if (r_obuf[i] !== exp_enc[167-8*i -: 8]) begin
        n_errors++; $display("FAIL stall_beat[%0d] got=%h want=%h", i, r_obuf[i], exp_enc[167-8*i -: 8]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, cyc;
    acc = 0; cyc = 0;
    start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (acc < 20 && cyc < 200) begin
      sif.in_valid = 1'b1;
      sif.in_data  = 8'h30 + 8'(acc);
      if (sif.in_ready) acc++;
      cyc++;
      @(negedge clk);
    end
    sif.in_valid = 1'b0;
    n_checks++; if (acc !== 20) begin n_errors++; $display("FAIL midrst_load got=%0d want=20", acc); end
    #2 rst = 1'b0;
    tb_key_loaded = 1'b0;
    #1;
    n_checks++;
    if ({busy, sif.in_ready, sif.out_valid, done} !== 4'b0) begin
      n_errors++; $display("FAIL midrst_ctrl got=%b want=0000", {busy, sif.in_ready, sif.out_valid, done});
    end
    n_checks++;
    if ({core_key, core_nonce} !== '0) begin
      n_errors++; $display("FAIL midrst_buses got=%h/%h want=0", core_key, core_nonce);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL midrst_done got=%b want=0", done); end
    run_txn(1'b0, 1'b1, pt_c, 128'h0, 1'b0, 1'b0);
    n_checks++; if ({r_to, r_n_in} !== {1'b0, 32'd42}) begin n_errors++; $display("FAIL midrst_fresh got=to%b/%0d want=to0/42", r_to, r_n_in); end
    for (int i = 0; i < 21; i++) begin
      n_checks++;
      if (r_obuf[i] !== exp_enc[167-8*i -: 8]) begin
        n_errors++; $display("FAIL midrst_beat[%0d] got=%h want=%h", i, r_obuf[i], exp_enc[167-8*i -: 8]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 1'b0, pt_c, 128'h0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, ct_c, tag_c, 1'b0, 1'b0);
    n_checks++; if (r_to !== 1'b0) begin n_errors++; $display("FAIL b2b_timeout got=%b want=0", r_to); end
    n_checks++; if (r_first_ready !== 0) begin n_errors++; $display("FAIL b2b_ready_lat got=%0d want=0", r_first_ready); end
    n_checks++; if ({auth_ok, r_obuf[4]} !== {1'b1, 8'h05}) begin n_errors++; $display("FAIL b2b_dec got=%b/%h want=1/05", auth_ok, r_obuf[4]); end
  endtask

`ifdef AEAD_KEY_REUSE_EN
  task automatic test_key_reuse();
    run_txn(1'b0, 1'b1, pt_c, 128'h0, 1'b0, 1'b0);
    n_checks++; if ({r_to, r_n_in} !== {1'b0, 32'd26}) begin n_errors++; $display("FAIL reuse_load got=to%b/%0d want=to0/26", r_to, r_n_in); end
    n_checks++; if (core_key !== key_c) begin n_errors++; $display("FAIL reuse_key got=%h want=%h", core_key, key_c); end
    for (int i = 0; i < 21; i++) begin
      n_checks++;
      if (r_obuf[i] !== exp_enc[167-8*i -: 8]) begin
        n_errors++; $display("FAIL reuse_beat[%0d] got=%h want=%h", i, r_obuf[i], exp_enc[167-8*i -: 8]);
      end
    end
  endtask
`endif

  initial begin
    key_c   = 128'h000102030405060708090A0B0C0D0E0F;
    nonce_c = 128'h101112131415161718191A1B1C1D1E1F;
    ad_c    = 40'h0A0B0C0D0E;
    pt_c    = 40'h0102030405;
    ct_c    = 40'h1112131415;
    tag_c   = 128'h1010101010101010101010_0B090F090B;
    exp_enc = {ct_c, tag_c};
    tb_key_loaded = 1'b0;
    rst = 1'b0; start = 1'b0; mode = 1'b0;
`ifdef AEAD_KEY_REUSE_EN
    key_reuse = 1'b0;
`endif
    core_done = 1'b0; core_text_out = '0; core_tag_out = '0;
    sif.in_data = '0; sif.in_valid = 1'b0; sif.out_ready = 1'b0; sif.rnd_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_encrypt();
    test_decrypt_ok();
    test_decrypt_fail();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef AEAD_KEY_REUSE_EN
    test_key_reuse();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
